// File: rtl/flood_open.sv
// flood_open: breadth-first reveal of a zero-count region on a minesweeper board,
// driving cover-store lookups and open commands one cell at a time.
module flood_open #(
  parameter int x_size = 16,
  parameter int y_size = 16,
  parameter int x_coord_bits = 4,
  parameter int y_coord_bits = 4,
  parameter int ack_timeout = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [x_coord_bits-1:0] start_x,
  input  logic [y_coord_bits-1:0] start_y,
  output logic [x_coord_bits-1:0] cell_x,
  output logic [y_coord_bits-1:0] cell_y,
  input  logic [1:0]              cover_state,
  input  logic [3:0]              adj_count,
  input  logic                    is_mine,
  output logic                    open_out,
  input  logic                    opened_cell,
  output logic                    busy,
  output logic                    done,
  output logic                    hit_mine,
  output logic [8:0]              cells_opened,
  output logic                    timeout_err
);
  localparam int N = x_size * y_size;
  localparam int AW = $clog2(N);
  localparam int PW = $clog2(N + 1);
  localparam int CW = x_coord_bits + y_coord_bits;
  localparam int TW = $clog2(ack_timeout + 1);
  typedef enum logic [2:0] {IDLE, POP, RD, OPEN, ACK, NEIGH, FIN} state_t;
  state_t state_q, state_d;
  logic [N-1:0] vis_q;
  logic [CW-1:0] fifo_q [N];
  logic [PW-1:0] rd_q, wr_q;
  logic [x_coord_bits-1:0] x_q;
  logic [y_coord_bits-1:0] y_q;
  logic [3:0] adj_q;
  logic mine_q, hit_q, tmo_q;
  logic [8:0] cnt_q;
  logic [TW-1:0] tmr_q;
  logic [2:0] nidx_q;
  logic empty, tmr_last, push, in_range;
  logic [CW-1:0] head, push_cell;
  logic [AW-1:0] push_idx, wr_idx;
  int nx, ny;
  assign empty = rd_q == wr_q;
  assign head = fifo_q[rd_q[AW-1:0]];
  assign tmr_last = tmr_q == TW'(ack_timeout - 1);
  assign wr_idx = state_q == IDLE ? '0 : wr_q[AW-1:0];
  // The seed push in IDLE and neighbour pushes in NEIGH share one write port.
  always_comb begin
    nx = int'(x_q) + ((nidx_q == 3'd0 || nidx_q == 3'd3 || nidx_q == 3'd5) ? -1 : (nidx_q == 3'd1 || nidx_q == 3'd6) ? 0 : 1);
    ny = int'(y_q) + (nidx_q < 3'd3 ? -1 : nidx_q < 3'd5 ? 0 : 1);
    in_range = nx >= 0 && nx < x_size && ny >= 0 && ny < y_size;
    push_idx = state_q == IDLE ? AW'(int'(start_y) * x_size + int'(start_x)) : AW'(ny * x_size + nx);
    push_cell = state_q == IDLE ? {start_y, start_x} : {y_coord_bits'(ny), x_coord_bits'(nx)};
    push = state_q == IDLE ? start : (state_q == NEIGH && in_range && !vis_q[push_idx]);
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = start ? POP : IDLE;
      POP:   state_d = empty ? FIN : RD;
      RD:    state_d = cover_state != 2'b00 ? POP : OPEN;
      OPEN:  state_d = ACK;
      ACK:   state_d = opened_cell ? ((!mine_q && adj_q == 4'd0) ? NEIGH : POP) : tmr_last ? POP : ACK;
      NEIGH: state_d = nidx_q == 3'd7 ? POP : NEIGH;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vis_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      x_q <= '0;
      y_q <= '0;
      adj_q <= '0;
      mine_q <= 1'b0;
      hit_q <= 1'b0;
      tmo_q <= 1'b0;
      cnt_q <= '0;
      tmr_q <= '0;
      nidx_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          vis_q <= N'(1) << push_idx;
          rd_q <= '0;
          wr_q <= PW'(1);
          cnt_q <= '0;
          hit_q <= 1'b0;
        end
        POP: if (!empty) begin
          {y_q, x_q} <= head;
          rd_q <= rd_q + 1'b1;
        end
        RD: begin
          adj_q <= adj_count;
          mine_q <= is_mine;
          tmr_q <= '0;
        end
        ACK: if (opened_cell) begin
          cnt_q <= cnt_q + 1'b1;
          hit_q <= hit_q | mine_q;
          nidx_q <= '0;
        end else if (tmr_last) tmo_q <= 1'b1;
        else tmr_q <= tmr_q + 1'b1;
        NEIGH: begin
          nidx_q <= nidx_q + 1'b1;
          if (push) begin
            vis_q[push_idx] <= 1'b1;
            wr_q <= wr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_idx] <= push_cell;
  end
  // During POP the head is presented directly so the registered lookup is valid in RD.
  assign cell_x = (state_q == POP && !empty) ? head[x_coord_bits-1:0] : x_q;
  assign cell_y = (state_q == POP && !empty) ? head[CW-1:x_coord_bits] : y_q;
  assign busy = state_q != IDLE;
  assign done = state_q == FIN;
  assign hit_mine = state_q == FIN && hit_q;
  assign open_out = state_q == OPEN;
  assign cells_opened = cnt_q;
  assign timeout_err = tmo_q;
endmodule

// File: doc/flood_open.md
FLOOD_OPEN -- requirements
Module: flood_open

Interface
REQ-001 The block SHALL have a parameter x_size, default 16, giving the board width in cells.
REQ-002 The block SHALL have a parameter y_size, default 16, giving the board height in cells.
REQ-003 The block SHALL have parameters x_coord_bits and y_coord_bits, default 4 each, giving the coordinate widths.
REQ-004 The block SHALL have a parameter ack_timeout, default 15, giving the maximum number of cycles to wait for an open acknowledge.
REQ-005 The block SHALL have the port clk, input, 1 bit, the single clock; all state SHALL be on its rising edge.
REQ-006 The block SHALL have the port reset, input, 1 bit, an asynchronous active-low reset.
REQ-007 The block SHALL have the port start, input, 1 bit, a one-cycle request to begin a reveal at start_x/start_y.
REQ-008 The block SHALL have the ports start_x and start_y, inputs, x_coord_bits/y_coord_bits wide, giving the seed cell.
REQ-009 The block SHALL have the ports cell_x and cell_y, outputs, x_coord_bits/y_coord_bits wide; they SHALL carry the address for the cover-state lookup, the board-value lookup and the open command.
REQ-010 The block SHALL have the port cover_state, input, 2 bits, the cover state for cell_x/cell_y with 1-cycle latency: 00 = unopened, 01 = opened, 10 = flagged.
REQ-011 The block SHALL have the ports adj_count (input, 4 bits, the adjacent-mine count) and is_mine (input, 1 bit, the mine flag), both with 1-cycle latency from cell_x/cell_y.
REQ-012 The block SHALL have the port open_out, output, 1 bit, a one-cycle open command for cell_x/cell_y.
REQ-013 The block SHALL have the port opened_cell, input, 1 bit, a pulse from the cover store acknowledging an accepted open.
REQ-014 The block SHALL have the port busy, output, 1 bit, high whenever the FSM is not in IDLE.
REQ-015 The block SHALL have the port done, output, 1 bit, a one-cycle pulse at the end of a reveal.
REQ-016 The block SHALL have the port hit_mine, output, 1 bit, a one-cycle pulse coincident with done when any opened cell had is_mine=1.
REQ-017 The block SHALL have the port cells_opened, output, 9 bits, the count of acknowledged opens in the current or last reveal.
REQ-018 The block SHALL have the port timeout_err, output, 1 bit, a sticky flag set when an acknowledge is missed.

Function
REQ-019 The FSM SHALL have the states IDLE, POP, RD, OPEN, ACK, NEIGH and FIN.
REQ-020 A start pulse SHALL be accepted only in IDLE; a start pulse while busy=1 SHALL be ignored.
REQ-021 On acceptance, the block SHALL clear the x_size*y_size visited bitmap, clear the FIFO, clear cells_opened, push the seed cell, mark it visited, and enter POP.
REQ-022 The block SHALL use a work FIFO of x_size*y_size entries; because each cell is pushed at most once, the FIFO SHALL never overflow, and a push-when-full is not required to be handled.
REQ-023 In POP, if the FIFO is empty, the block SHALL go to FIN; otherwise it SHALL pop the head onto cell_x/cell_y and go to RD.
REQ-024 In RD (one cycle later), the block SHALL sample cover_state, adj_count and is_mine; if cover_state != 00 (opened or flagged), it SHALL skip the cell and return to POP; otherwise it SHALL go to OPEN.
REQ-025 In OPEN, open_out SHALL be 1 for exactly one cycle with cell_x/cell_y held, and the block SHALL then enter ACK.
REQ-026 In ACK, cell_x/cell_y SHALL be held and open_out SHALL be 0.
REQ-027 If opened_cell arrives within ack_timeout cycles, the block SHALL increment cells_opened and record a mine hit if is_mine=1.
REQ-028 After an acknowledge, if is_mine=0 and adj_count=0, the block SHALL go to NEIGH with index 0; otherwise it SHALL go to POP.
REQ-029 If no opened_cell arrives within ack_timeout cycles, the block SHALL set timeout_err, leave cells_opened unchanged, and go to POP.
REQ-030 In NEIGH, the block SHALL evaluate one neighbour per cycle in the order (-1,-1), (0,-1), (+1,-1), (-1,0), (+1,0), (-1,+1), (0,+1), (+1,+1).
REQ-031 In NEIGH, a neighbour outside 0..x_size-1 or 0..y_size-1 SHALL be skipped with no wrap-around, and a visited neighbour SHALL be skipped; any other neighbour SHALL be pushed and marked visited.
REQ-032 After index 7, the block SHALL go to POP, so NEIGH always takes exactly 8 cycles.
REQ-033 Once a mine hit is recorded, no further neighbour expansion SHALL occur for that cell; the remaining FIFO entries SHALL still be processed.
REQ-034 In FIN, done SHALL be 1 for one cycle, hit_mine SHALL equal the recorded mine flag, and the block SHALL return to IDLE with busy=0.
REQ-035 cells_opened SHALL hold its value in IDLE until the next accepted start.
REQ-036 opened_cell arriving outside ACK SHALL be ignored.

Reset
REQ-037 While reset=0, the state SHALL be IDLE and busy, done, hit_mine, open_out, timeout_err, cells_opened, cell_x and cell_y SHALL all be 0, and the FIFO pointers and the visited bitmap SHALL be cleared.
REQ-038 Reset asserted mid-reveal SHALL abort immediately with no further open_out; after release the block SHALL be in IDLE awaiting start.

Verification
REQ-039 A 16x16 board with no mines, all unopened, start at (0,0), and an opened_cell ack 1 cycle after each open_out SHALL give 256 open_out pulses, each cell exactly once, done with cells_opened=256, hit_mine=0.
REQ-040 A seed at (5,5) with adj_count=2 SHALL give exactly one open_out at (5,5), then done with cells_opened=1 and no neighbour lookups.
REQ-041 A seed at (15,15) with a zero region SHALL never put a lookup address outside 0..15, showing no wrap to column or row 0.
REQ-042 A flagged cell (cover_state=10) inside a zero region SHALL never have open_out asserted at its address, and the flag SHALL remain.
REQ-043 A seed cell with is_mine=1 SHALL give one open_out, then done and hit_mine pulsing together with cells_opened=1.
REQ-044 Withholding opened_cell for 16 cycles SHALL set timeout_err=1 and let the reveal complete; a start while busy SHALL be ignored; reset=0 mid-NEIGH SHALL force busy=0 and open_out=0 at once.
